hull_fifo_reader: RTL and testbench

Read-side adapter that drains a HullFIFO read port (q/empty/rdreq) and presents a registered valid/ready stream with burst framing (m_last every cfg_burst_len beats). Sits between any HullFIFO instance and a downstream AXI-stream-style consumer, so consumers never handle rdreq timing or FIFO read latency. Sustains one beat per cycle under continuous ready for either FIFO read latency.

---
 rtl/aos_stream_pkg.sv | 14 +
 rtl/stream_skid_buf.sv | 74 +++++++
 rtl/hull_fifo_reader.sv | 110 +++++++++++
 tb/tb_hull_fifo_reader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aos_stream_pkg.sv
// Shared definitions for the AOS stream adapters: burst-length width, beat
// counter type and the zero-means-one burst length rule.
package aos_stream_pkg;

    localparam int BURST_LEN_W = 16;

    typedef logic [BURST_LEN_W-1:0] beat_cnt_t;

    // A configured length of zero behaves as single-beat bursts.
    function automatic beat_cnt_t eff_burst_len(input beat_cnt_t len);
        return (len == '0) ? beat_cnt_t'(1) : len;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Circular register buffer: push writes the tail, pop retires the head, and
// the head entry is always presented so the consumer sees registered data.
module stream_skid_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_i && (tail_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        head_d  = pop_i  ? ptr_inc(head_q) : head_q;
        tail_d  = push_i ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_q[i] <= push_data_i;
                end
            end
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;

    // The issuer reserves space before reading, so overflow/underflow mean a bug upstream.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        push_i |-> (count_q != CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        pop_i |-> (count_q != '0));

endmodule

// File: rtl/hull_fifo_reader.sv
// Drains a HullFIFO read port into a registered valid/ready stream with
// m_last framing every cfg_burst_len beats, for read latency 0 or 1.
module hull_fifo_reader
    import aos_stream_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int RD_LATENCY = 0,
    localparam int BUF_DEPTH  = 2 + RD_LATENCY
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       fifo_q,
    input  logic                   fifo_empty,
    output logic                   fifo_rdreq,
    input  logic [BURST_LEN_W-1:0] cfg_burst_len,
    output logic                   m_valid,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   busy
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             inflight;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] head_data;
    logic             handshake;
    beat_cnt_t        beat_cnt_q, beat_cnt_d;
    beat_cnt_t        len_q, len_d;
    beat_cnt_t        eff_len;

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign inflight  = 1'b0;
            assign push      = fifo_rdreq;
            assign push_data = fifo_q;
        end else if (RD_LATENCY == 1) begin : g_lat1
            logic inflight_q;
            // A back-to-back read keeps one word in flight every cycle.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    inflight_q <= 1'b0;
                end else begin
                    inflight_q <= fifo_rdreq;
                end
            end
            assign inflight  = inflight_q;
            assign push      = inflight_q;
            assign push_data = fifo_q;
        end else begin : g_bad_latency
            $error("hull_fifo_reader: RD_LATENCY must be 0 or 1");
            assign inflight  = 1'b0;
            assign push      = 1'b0;
            assign push_data = '0;
        end
    endgenerate

    // Reserve a buffer slot for every word already requested, independent of m_ready.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign fifo_rdreq = reset_n && !fifo_empty && (occupancy < (CNT_W + 1)'(BUF_DEPTH));

    stream_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (handshake),
        .head_data_o (head_data),
        .count_o     (count)
    );

    assign m_valid   = (count != '0);
    assign m_data    = head_data;
    assign handshake = m_valid && m_ready;

    // The burst length is sampled only at the first beat of a burst.
    assign eff_len = (beat_cnt_q == '0) ? eff_burst_len(cfg_burst_len) : len_q;
    assign m_last  = m_valid && (beat_cnt_q == eff_len - 1'b1);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        if (handshake) begin
            if (beat_cnt_q == '0) begin
                len_d = eff_burst_len(cfg_burst_len);
            end
            beat_cnt_d = m_last ? '0 : beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
            len_q      <= beat_cnt_t'(1);
        end else begin
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
        end
    end

    assign busy = (beat_cnt_q != '0) || (count != '0) || inflight;

endmodule

// File: tb/tb_hull_fifo_reader.sv
// Bench for hull_fifo_reader: one instance per read latency, each fed by a
// behavioural FIFO; a monitor checks order, framing, busy and occupancy.
module tb_hull_fifo_reader;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [W-1:0]  fifo_q     [2];
    logic          fifo_empty [2];
    logic          fifo_rdreq [2];
    logic [15:0]   cfg        [2];
    logic          m_valid    [2];
    logic [W-1:0]  m_data     [2];
    logic          m_last     [2];
    logic          m_ready    [2];
    logic          busy       [2];

    // Behavioural FIFOs: index 0 show-ahead, index 1 registered read.
    logic [W-1:0]  fmem [2][256];
    logic [7:0]    frd  [2];
    logic [7:0]    fwr  [2];
    logic [W-1:0]  q1_reg;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frd[0] <= 8'd0;
            frd[1] <= 8'd0;
            q1_reg <= '0;
        end else begin
            if (fifo_rdreq[0]) frd[0] <= frd[0] + 8'd1;
            if (fifo_rdreq[1]) begin
                frd[1] <= frd[1] + 8'd1;
                q1_reg <= fmem[1][frd[1]];
            end
        end
    end

    assign fifo_empty[0] = (frd[0] == fwr[0]);
    assign fifo_empty[1] = (frd[1] == fwr[1]);
    assign fifo_q[0]     = fmem[0][frd[0]];
    assign fifo_q[1]     = q1_reg;

    hull_fifo_reader #(.WIDTH(W), .RD_LATENCY(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .fifo_q(fifo_q[0]), .fifo_empty(fifo_empty[0]),
        .fifo_rdreq(fifo_rdreq[0]), .cfg_burst_len(cfg[0]), .m_valid(m_valid[0]),
        .m_data(m_data[0]), .m_last(m_last[0]), .m_ready(m_ready[0]), .busy(busy[0]));

    hull_fifo_reader #(.WIDTH(W), .RD_LATENCY(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .fifo_q(fifo_q[1]), .fifo_empty(fifo_empty[1]),
        .fifo_rdreq(fifo_rdreq[1]), .cfg_burst_len(cfg[1]), .m_valid(m_valid[1]),
        .m_data(m_data[1]), .m_last(m_last[1]), .m_ready(m_ready[1]), .busy(busy[1]));

    int n_pass = 0;
    int n_total = 0;

    // Monitor / reference model state.
    int         cyc = 0;
    int         hs_cnt [2];
    int         last_cnt [2];
    int         first_valid_cyc [2];
    int         first_hs_cyc [2];
    int         last_hs_cyc [2];
    int         first_last_idx [2];
    int         rem [2];
    logic [7:0] optr [2];
    logic       pv [2];
    logic       pr [2];
    logic       pl [2];
    logic [W-1:0] pdat [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic monitor();
        logic [7:0] occ;
        logic       exp_last;
        forever begin
            @(negedge clock);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!reset_n) begin
                    chk("rst_m_valid", 32'(m_valid[d]), 32'd0);
                    chk("rst_m_last", 32'(m_last[d]), 32'd0);
                    chk("rst_m_data", m_data[d], 32'd0);
                    chk("rst_rdreq", 32'(fifo_rdreq[d]), 32'd0);
                    chk("rst_busy", 32'(busy[d]), 32'd0);
                    hs_cnt[d] = 0;  last_cnt[d] = 0;  rem[d] = 0;  optr[d] = 8'd0;
                    first_valid_cyc[d] = -1;  first_hs_cyc[d] = -1;
                    last_hs_cyc[d] = -1;  first_last_idx[d] = -1;
                    pv[d] = 1'b0;  pr[d] = 1'b0;  pl[d] = 1'b0;  pdat[d] = '0;
                end else begin
                    // Words taken from the FIFO but not yet delivered downstream.
                    occ = frd[d] - optr[d];
                    chk("occupancy_le_depth", 32'(occ <= 8'(2 + d)), 32'd1);
                    chk("busy", 32'(busy[d]), 32'((rem[d] != 0) || (occ != 8'd0)));
                    if (fifo_rdreq[d]) chk("rdreq_when_empty", 32'(fifo_empty[d]), 32'd0);
                    if (pv[d] && !pr[d]) begin
                        chk("hold_valid", 32'(m_valid[d]), 32'd1);
                        chk("hold_data", m_data[d], pdat[d]);
                        chk("hold_last", 32'(m_last[d]), 32'(pl[d]));
                    end
                    if (!m_valid[d]) chk("last_without_valid", 32'(m_last[d]), 32'd0);
                    if (m_valid[d] && first_valid_cyc[d] < 0) first_valid_cyc[d] = cyc;
                    if (m_valid[d] && m_ready[d]) begin
                        if (rem[d] == 0) rem[d] = (cfg[d] == 16'd0) ? 1 : int'(cfg[d]);
                        exp_last = (rem[d] == 1);
                        rem[d]--;
                        chk("data_order", m_data[d], fmem[d][optr[d]]);
                        chk("m_last", 32'(m_last[d]), 32'(exp_last));
                        if (m_last[d]) begin
                            if (first_last_idx[d] < 0) first_last_idx[d] = hs_cnt[d];
                            last_cnt[d]++;
                        end
                        if (first_hs_cyc[d] < 0) first_hs_cyc[d] = cyc;
                        last_hs_cyc[d] = cyc;
                        optr[d] = optr[d] + 8'd1;
                        hs_cnt[d]++;
                    end
                    pv[d] = m_valid[d];  pr[d] = m_ready[d];
                    pl[d] = m_last[d];   pdat[d] = m_data[d];
                end
            end
        end
    endtask

    task automatic push(input int d, input logic [W-1:0] v);
        fmem[d][fwr[d]] = v;
        fwr[d] = fwr[d] + 8'd1;
    endtask

    task automatic push_both(input logic [W-1:0] v);
        push(0, v);
        push(1, v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step(1);
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            fwr[d] = 8'd0;
            m_ready[d] = 1'b0;
        end
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_hs(input int n, input int budget);
        int t;
        t = 0;
        while ((hs_cnt[0] < n || hs_cnt[1] < n) && t < budget) begin
            step(1);
            t++;
        end
        chk("wait_beats_delivered", 32'((hs_cnt[0] >= n) && (hs_cnt[1] >= n)), 32'd1);
    endtask

    typedef struct {
        logic [15:0] len;
        int          beats;
        int          exp_lasts;
        int          exp_first_last;
    } vec_t;

    vec_t vec [6];

    initial begin
        int push_cyc;
        int npush;
        int t;
        logic [W-1:0] v;

        for (int d = 0; d < 2; d++) begin
            fwr[d] = 8'd0;  m_ready[d] = 1'b0;  cfg[d] = 16'd4;
        end
        vec[0] = '{16'd4, 16, 4, 3};
        vec[1] = '{16'd0,  5, 5, 0};
        vec[2] = '{16'd1,  3, 3, 0};
        vec[3] = '{16'd3,  9, 3, 2};
        vec[4] = '{16'd2,  8, 4, 1};
        vec[5] = '{16'd5,  7, 1, 4};

        fork
            monitor();
        join_none

        // Table: streaming with m_ready held high.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int d = 0; d < 2; d++) begin
                cfg[d] = vec[r].len;
                m_ready[d] = 1'b1;
            end
            push_cyc = cyc;
            for (int i = 0; i < vec[r].beats; i++) begin
                v = (r == 0) ? W'(i) : $urandom;
                push_both(v);
            end
            wait_hs(vec[r].beats, 100);
            for (int d = 0; d < 2; d++) begin
                chk("vec_beats", 32'(hs_cnt[d]), 32'(vec[r].beats));
                chk("vec_last_count", 32'(last_cnt[d]), 32'(vec[r].exp_lasts));
                chk("vec_first_last", 32'(first_last_idx[d]), 32'(vec[r].exp_first_last));
                chk("vec_no_bubble", 32'(last_hs_cyc[d] - first_hs_cyc[d]), 32'(vec[r].beats - 1));
                chk("vec_latency", 32'(first_valid_cyc[d] - push_cyc - 1), 32'(1 + d));
            end
            $display("vector %0d: len=%0d beats=%0d lasts=%0d/%0d", r, vec[r].len,
                     vec[r].beats, last_cnt[0], last_cnt[1]);
        end

        // Backpressure: the buffer fills to its depth and the head holds.
        do_reset();
        for (int i = 0; i < 8; i++) push_both(W'(100 + i));
        step(10);
        for (int d = 0; d < 2; d++) begin
            chk("bp_taken", 32'(frd[d]), 32'(2 + d));
            chk("bp_valid", 32'(m_valid[d]), 32'd1);
            chk("bp_head", m_data[d], 32'd100);
            m_ready[d] = 1'b1;
        end
        wait_hs(8, 50);
        $display("backpressure: taken before release, drained %0d/%0d", hs_cnt[0], hs_cnt[1]);

        // Alternating ready over 32 beats.
        do_reset();
        for (int i = 0; i < 32; i++) push_both($urandom);
        t = 0;
        while ((hs_cnt[0] < 32 || hs_cnt[1] < 32) && t < 200) begin
            for (int d = 0; d < 2; d++) m_ready[d] = ~t[0];
            step(1);
            t++;
        end
        chk("toggle_done", 32'((hs_cnt[0] == 32) && (hs_cnt[1] == 32)), 32'd1);
        $display("toggle ready: delivered %0d/%0d", hs_cnt[0], hs_cnt[1]);

        // Burst length change mid-burst applies from the next burst.
        do_reset();
        for (int d = 0; d < 2; d++) begin
            cfg[d] = 16'd4;
            m_ready[d] = 1'b1;
        end
        for (int i = 0; i < 8; i++) push_both($urandom);
        t = 0;
        while ((hs_cnt[0] < 8 || hs_cnt[1] < 8) && t < 60) begin
            for (int d = 0; d < 2; d++) if (hs_cnt[d] >= 1) cfg[d] = 16'd2;
            step(1);
            t++;
        end
        for (int d = 0; d < 2; d++) begin
            chk("cfgchg_first_last", 32'(first_last_idx[d]), 32'd3);
            chk("cfgchg_last_count", 32'(last_cnt[d]), 32'd3);
        end
        $display("cfg change: lasts=%0d/%0d", last_cnt[0], last_cnt[1]);

        // Reset at beat 2 of a 4-beat burst with words buffered.
        do_reset();
        for (int d = 0; d < 2; d++) begin
            cfg[d] = 16'd4;
            m_ready[d] = 1'b1;
        end
        for (int i = 0; i < 6; i++) push_both($urandom);
        t = 0;
        while ((m_ready[0] || m_ready[1]) && t < 40) begin
            for (int d = 0; d < 2; d++) if (hs_cnt[d] >= 2) m_ready[d] = 1'b0;
            step(1);
            t++;
        end
        step(3);
        for (int d = 0; d < 2; d++) chk("mid_busy_before_reset", 32'(busy[d]), 32'd1);
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("mid_rst_valid_now", 32'(m_valid[d]), 32'd0);
            chk("mid_rst_rdreq_now", 32'(fifo_rdreq[d]), 32'd0);
            fwr[d] = 8'd0;
        end
        step(2);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) push_both($urandom);
        for (int d = 0; d < 2; d++) m_ready[d] = 1'b1;
        wait_hs(5, 50);
        for (int d = 0; d < 2; d++) begin
            chk("mid_rst_first_last", 32'(first_last_idx[d]), 32'd3);
            chk("mid_rst_last_count", 32'(last_cnt[d]), 32'd1);
        end
        $display("mid-burst reset: first last at beat %0d/%0d", first_last_idx[0], first_last_idx[1]);

        // Sparse FIFO: one word every three cycles.
        do_reset();
        for (int d = 0; d < 2; d++) begin
            cfg[d] = 16'd4;
            m_ready[d] = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            push_both($urandom);
            step(3);
        end
        wait_hs(8, 20);
        for (int d = 0; d < 2; d++) chk("sparse_last_count", 32'(last_cnt[d]), 32'd2);
        $display("sparse fifo: delivered %0d/%0d", hs_cnt[0], hs_cnt[1]);

        // Randomised traffic, ready and burst length.
        do_reset();
        npush = 0;
        for (int c = 0; c < 400; c++) begin
            if (npush < 150 && $urandom_range(1, 0) == 1) begin
                push_both($urandom);
                npush++;
            end
            for (int d = 0; d < 2; d++) begin
                m_ready[d] = ($urandom_range(3, 0) != 0);
                if ($urandom_range(15, 0) == 0) cfg[d] = 16'($urandom_range(5, 0));
            end
            step(1);
        end
        for (int d = 0; d < 2; d++) m_ready[d] = 1'b1;
        wait_hs(npush, 400);
        for (int d = 0; d < 2; d++) chk("random_count", 32'(hs_cnt[d]), 32'(npush));
        $display("random: pushed %0d delivered %0d/%0d", npush, hs_cnt[0], hs_cnt[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
